// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared defaults and sizing helpers for the skid-buffered pipe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int DEF_WIDTH = 160;
    localparam int DEF_LANES = 1;
    localparam int DEF_DEPTH = 2;

    // Total payload bits of one bundle; lane k lives at [k*width +: width].
    function automatic int bundle_w(input int lanes, input int width);
        return lanes * width;
    endfunction

    // Pointer width, kept at least one bit so DEPTH=1 still has a legal vector.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_skid_mem.sv
// ============================================================================
//  Module   : pipe_skid_mem
//  Purpose  : Payload storage, one write port and one asynchronous read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    // Payload is never reset; validity is tracked by the controller's masks.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
//  Module   : pipe_skid_reg
//  Purpose  : Multi-lane circular skid buffer with flush and registered ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [LANES-1:0]             in_lane_valid,
    input  logic [LANES*WIDTH-1:0]       in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [LANES-1:0]             out_lane_valid,
    output logic [LANES*WIDTH-1:0]       out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         flushed
);

    localparam int DW    = bundle_w(LANES, WIDTH);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q,  count_d;
    logic [DEPTH-1:0][LANES-1:0] mask_q,   mask_d;
    logic                        flushed_q, flushed_d;

    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_rdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Ready depends on stored count only, so there is no out_ready -> in_ready path.
    assign in_ready  = (count_q < CNT_FULL);
    assign out_valid = (count_q != '0) && !flush;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mask_d    = mask_q;
        flushed_d = 1'b0;
        if (flush) begin
            // Popped slots have their masks cleared, so the OR covers only live bundles.
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            mask_d    = '0;
            flushed_d = |mask_q;
        end else begin
            if (w_pop) begin
                mask_d[rd_ptr_q] = '0;
                rd_ptr_d         = ptr_inc(rd_ptr_q);
            end
            if (w_push) begin
                mask_d[wr_ptr_q] = in_lane_valid;
                wr_ptr_d         = ptr_inc(wr_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            mask_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mask_q    <= mask_d;
            flushed_q <= flushed_d;
        end
    end

    pipe_skid_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_rdata)
    );

    assign out_lane_valid = out_valid ? mask_q[rd_ptr_q] : '0;
    assign out_data       = out_valid ? w_rdata : '0;
    assign count          = count_q;
    assign flushed        = flushed_q;

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 160: payload bits per lane.
REQ-002 Parameter LANES, default 1: parallel issue lanes carried as one bundle; legal range 1..4.
REQ-003 Parameter DEPTH, default 2: bundle entries buffered; legal range 1..8, non-power-of-2 allowed.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous kill of all held and incoming bundles (branch mispredict).
REQ-007 in_valid  in  1  upstream offers a bundle this cycle.
REQ-008 in_lane_valid  in  LANES  per-lane occupancy of the offered bundle; 0 marks a bubble slot.
REQ-009 in_data  in  LANES*WIDTH  bundle payload; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-010 in_ready  out  1  block can accept a bundle this cycle.
REQ-011 out_valid  out  1  head bundle presented downstream.
REQ-012 out_lane_valid  out  LANES  lane mask of the head bundle.
REQ-013 out_data  out  LANES*WIDTH  head bundle payload.
REQ-014 out_ready  in  1  downstream consumes the head this cycle; low means hold.
REQ-015 count  out  clog2(DEPTH+1)  bundles currently stored.
REQ-016 flushed  out  1  one-cycle pulse: the preceding flush discarded at least one valid lane.

Function
REQ-017 A push SHALL occur when in_valid && in_ready && !flush; a pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be (count < DEPTH), a function of registered state only, with no path from out_ready.
REQ-019 Latency SHALL be one cycle: a bundle pushed at edge N is visible at out_* after edge N.
REQ-020 With DEPTH >= 2 and out_ready held high, one bundle SHALL transfer per cycle; with DEPTH = 1, at most one bundle per two cycles.
REQ-021 Storage SHALL be a circular buffer; read and write pointers wrap from DEPTH-1 to 0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 out_valid SHALL be (count != 0) && !flush; no pop can occur during a flush cycle.
REQ-024 When out_valid is 0, out_lane_valid and out_data SHALL be all zeros.
REQ-025 A bundle whose in_lane_valid is all zeros SHALL still be stored and delivered as a bubble; it SHALL NOT be dropped.
REQ-026 When flush is 1 at an edge, count, both pointers and every stored lane-valid bit SHALL clear, and any offered bundle SHALL be discarded; flush overrides push and pop.
REQ-027 flushed SHALL be 1 in the cycle after a flush edge if any stored bundle had a nonzero lane mask, and 0 otherwise.
REQ-028 Under hold (out_ready = 0), out_* SHALL remain stable until popped or flushed.
REQ-029 While full, in_valid SHALL be ignored and input data SHALL NOT be sampled.

Reset
REQ-030 When rst_n is low, count, the pointers, the stored lane masks and flushed SHALL be 0 immediately, without waiting for a clock edge.
REQ-031 After reset, in_ready = 1 and out_valid = 0; payload storage need not be reset.
REQ-032 Reset asserted mid-transfer SHALL discard all contents; the first push after rst_n rises is delivered normally.

Structure
REQ-033 pipe_pkg SHALL hold the default WIDTH/LANES/DEPTH constants and the lane-slice width helper.
REQ-034 The payload array SHALL be a sub-module, pipe_skid_mem: DEPTH x LANES*WIDTH, one write port, one asynchronous read port, no reset.
REQ-035 Control (pointers, count, masks, flushed) SHALL reside in pipe_skid_reg.

Verification
REQ-036 DEPTH=2, LANES=2: push bundles A..D back-to-back with out_ready=1 -> A..D emerge on consecutive cycles, one cycle after push; count stays at 1.
REQ-037 DEPTH=2: push A and B with out_ready=0 -> count=2 and in_ready=0; offer C -> C not accepted; raise out_ready -> A, then B; C is accepted once in_ready=1.
REQ-038 DEPTH=3: push 3 bundles, pop 1, push 1, repeat 10 times -> data order preserved across pointer wrap; count never exceeds 3.
REQ-039 Hold 2 bundles (masks 2'b01, 2'b00), assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, flushed=1; flush with only 2'b00 bundles stored -> flushed=0.
REQ-040 Drop rst_n between edges with 2 bundles stored -> count=0 and out_valid=0 before the next edge; after release, bundle E pushed -> E delivered unaltered.
REQ-041 Push an all-zero-mask bundle -> delivered with out_valid=1 and out_lane_valid=0.
